// File: rtl/cu_pkg.sv
// Shared types for the CU-side decode issuer: the decoded bundle layout,
// the issuer state encoding and the next-PC helper.
package cu_pkg;

  localparam int DEC_BUNDLE_W = 98;

  // Field order matches the decoder's dec_fields bus, MSB first.
  typedef struct packed {
    logic [5:0]  instruction_to_cu;
    logic [4:0]  instruction_to_alu;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  shamt;
    logic [31:0] pc_increment;
    logic [1:0]  pipeline_override;
    logic        invalid_instruction;
  } dec_bundle_t;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } issuer_state_e;

  // 32-bit next-PC; the carry out of bit 31 is intentionally dropped.
  function automatic logic [31:0] calc_next_pc(input logic [31:0] pc,
                                               input logic [31:0] inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/cu_issue_timer.sv
// Loadable saturating up/down counter. The issuer uses it counting down for
// the decoder-flush hold and counting up for the decode timeout.
module cu_issue_timer #(
  parameter int CNT_W   = 5,
  parameter int RST_VAL = 3,
  parameter int TERM_UP = 15
) (
  input  logic             soc_clk,
  input  logic             ID_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             cnt_en,
  input  logic             cnt_up,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  // Counter register: load wins, otherwise step and saturate at either end.
  always_ff @(posedge soc_clk or posedge ID_reset) begin
    if (ID_reset) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_en) begin
      if (cnt_up) begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Terminal count depends on the direction requested this cycle.
  assign tc = cnt_up ? (cnt_q == CNT_W'(TERM_UP)) : (cnt_q == '0);

endmodule

// File: rtl/cu_decode_issuer.sv
// CU-side decode handshake initiator: issues one instruction to the ID
// wrapper, waits for a fresh IDU_ready edge, holds the decoded bundle for
// execute, and owns decoder flush plus illegal/timeout traps.
module cu_decode_issuer
  import cu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int FLUSH_CYC   = 4
) (
  input  logic        soc_clk,
  input  logic        ID_reset,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  output logic        decode_start,
  output logic [31:0] Cu_IR,
  output logic        IDU_reset,
  input  logic        IDU_ready,
  input  logic [97:0] dec_fields,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [97:0] ex_bundle,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_next_pc,
  output logic        trap_illegal,
  output logic        trap_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  issuer_state_e    state, state_n;
  dec_bundle_t      dec, bundle_q;
  logic [31:0]      ir_q, pc_q, ex_pc_q, ex_next_pc_q;
  logic             rdy_q, rise;
  logic             tmr_load, tmr_en, tmr_up, tmr_tc;
  logic [CNT_W-1:0] tmr_val;
  logic             accept, capture;
  logic             trap_ill_n, trap_tmo_n, trap_ill_q, trap_tmo_q;

  assign dec  = dec_fields;
  assign rise = IDU_ready & ~rdy_q;

  cu_issue_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (FLUSH_CYC - 1),
    .TERM_UP (TIMEOUT_CYC - 1)
  ) u_timer (
    .soc_clk  (soc_clk),
    .ID_reset (ID_reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt_en   (tmr_en),
    .cnt_up   (tmr_up),
    .tc       (tmr_tc)
  );

  // State register.
  always_ff @(posedge soc_clk or posedge ID_reset) begin
    if (ID_reset) state <= ST_FLUSH;
    else          state <= state_n;
  end

  // Next state and timer control; flush overrides everything, then timeout,
  // then capture, then the execute handshake, then fetch.
  always_comb begin
    state_n    = state;
    tmr_load   = 1'b0;
    tmr_val    = CNT_W'(FLUSH_CYC - 1);
    tmr_en     = 1'b0;
    tmr_up     = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    trap_ill_n = 1'b0;
    trap_tmo_n = 1'b0;
    if (flush) begin
      state_n  = ST_FLUSH;
      tmr_load = 1'b1;
    end else begin
      case (state)
        ST_FLUSH: begin
          tmr_en = 1'b1;
          if (tmr_tc) state_n = ST_IDLE;
        end
        ST_IDLE: begin
          if (fetch_valid) begin
            accept  = 1'b1;
            state_n = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmr_load = 1'b1;
          tmr_val  = '0;
          state_n  = ST_WAIT;
        end
        ST_WAIT: begin
          tmr_en = 1'b1;
          tmr_up = 1'b1;
          if (tmr_tc) begin
            trap_tmo_n = 1'b1;
            tmr_load   = 1'b1;
            state_n    = ST_FLUSH;
          end else if (rise) begin
            if (dec.invalid_instruction) begin
              trap_ill_n = 1'b1;
              tmr_load   = 1'b1;
              state_n    = ST_FLUSH;
            end else begin
              capture = 1'b1;
              state_n = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (ex_ready) state_n = ST_IDLE;
        end
        default: begin
          state_n  = ST_FLUSH;
          tmr_load = 1'b1;
        end
      endcase
    end
  end

  // IDU_ready history; forced high at ISSUE so a ready left over from the
  // previous decode must drop before an edge can be accepted.
  always_ff @(posedge soc_clk or posedge ID_reset) begin
    if (ID_reset)                rdy_q <= 1'b1;
    else if (state == ST_ISSUE)  rdy_q <= 1'b1;
    else if (state == ST_WAIT)   rdy_q <= IDU_ready;
  end

  // Instruction latch at accept and bundle/PC capture at the ready edge.
  always_ff @(posedge soc_clk or posedge ID_reset) begin
    if (ID_reset) begin
      ir_q         <= '0;
      pc_q         <= '0;
      bundle_q     <= '0;
      ex_pc_q      <= '0;
      ex_next_pc_q <= '0;
    end else begin
      if (accept) begin
        ir_q <= fetch_instr;
        pc_q <= fetch_pc;
      end
      if (capture) begin
        bundle_q     <= dec;
        ex_pc_q      <= pc_q;
        ex_next_pc_q <= calc_next_pc(pc_q, dec.pc_increment);
      end
    end
  end

  // Registered one-cycle trap pulses.
  always_ff @(posedge soc_clk or posedge ID_reset) begin
    if (ID_reset) begin
      trap_ill_q <= 1'b0;
      trap_tmo_q <= 1'b0;
    end else begin
      trap_ill_q <= trap_ill_n;
      trap_tmo_q <= trap_tmo_n;
    end
  end

  assign fetch_ready  = (state == ST_IDLE) & ~flush;
  assign decode_start = (state == ST_ISSUE);
  assign IDU_reset    = (state == ST_FLUSH);
  assign ex_valid     = (state == ST_HOLD);
  assign Cu_IR        = ir_q;
  assign ex_bundle    = bundle_q;
  assign ex_pc        = ex_pc_q;
  assign ex_next_pc   = ex_next_pc_q;
  assign trap_illegal = trap_ill_q;
  assign trap_timeout = trap_tmo_q;

endmodule

// File: tb/tb_cu_decode_issuer.sv
// Bench for cu_decode_issuer: directed sequences with a scoreboard of
// expected execute transfers and trap pulses.
module tb_cu_decode_issuer;

  localparam int K_EX  = 1;
  localparam int K_ILL = 2;
  localparam int K_TMO = 3;

  logic        soc_clk = 1'b0;
  logic        ID_reset, flush, fetch_valid;
  logic [31:0] fetch_instr, fetch_pc;
  logic        fetch_ready, decode_start;
  logic [31:0] Cu_IR;
  logic        IDU_reset, IDU_ready;
  logic [97:0] dec_fields;
  logic        ex_valid, ex_ready;
  logic [97:0] ex_bundle;
  logic [31:0] ex_pc, ex_next_pc;
  logic        trap_illegal, trap_timeout;

  typedef struct {
    int          kind;
    logic [97:0] b;
    logic [31:0] pc;
    logic [31:0] npc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  cu_decode_issuer dut (
    .soc_clk      (soc_clk),
    .ID_reset     (ID_reset),
    .flush        (flush),
    .fetch_valid  (fetch_valid),
    .fetch_instr  (fetch_instr),
    .fetch_pc     (fetch_pc),
    .fetch_ready  (fetch_ready),
    .decode_start (decode_start),
    .Cu_IR        (Cu_IR),
    .IDU_reset    (IDU_reset),
    .IDU_ready    (IDU_ready),
    .dec_fields   (dec_fields),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_bundle    (ex_bundle),
    .ex_pc        (ex_pc),
    .ex_next_pc   (ex_next_pc),
    .trap_illegal (trap_illegal),
    .trap_timeout (trap_timeout)
  );

  always #5 soc_clk = ~soc_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [97:0] mk(input logic [31:0] imm, input logic [31:0] inc,
                                     input logic inv);
    return {6'h13, 5'h02, imm, 5'd1, 5'd2, 5'd3, 5'd4, inc, 2'b01, inv};
  endfunction

  task automatic step();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge soc_clk);
  endtask

  task automatic push(input int kind, input logic [97:0] b, input logic [31:0] pc,
                      input logic [31:0] inc);
    exp_t e;
    e.kind = kind;
    e.b    = b;
    e.pc   = pc;
    e.npc  = pc + inc;
    sb.push_back(e);
  endtask

  task automatic sb_event(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_event", kind, 0);
    end else begin
      e = sb.pop_front();
      check("sb_kind", kind, e.kind);
      if (kind == K_EX) begin
        check("sb_bundle", ex_bundle, e.b);
        check("sb_pc", ex_pc, e.pc);
        check("sb_next_pc", ex_next_pc, e.npc);
      end
    end
  endtask

  // Output monitor: every transfer or trap pulse must match the next expectation.
  always @(negedge soc_clk) begin
    if (!ID_reset) begin
      if (ex_valid && ex_ready) sb_event(K_EX);
      if (trap_illegal)         sb_event(K_ILL);
      if (trap_timeout)         sb_event(K_TMO);
    end
  end

  // Called at the end of the first FLUSH cycle: three more with IDU_reset,
  // then IDLE.
  task automatic chk_flush();
    for (int i = 0; i < 3; i++) begin
      step();
      smp();
      check("flush_idu_reset", IDU_reset, 1);
      check("flush_fetch_ready", fetch_ready, 0);
      check("flush_ex_valid", ex_valid, 0);
      check("flush_trap_pulse", {trap_illegal, trap_timeout}, 0);
    end
    step();
    smp();
    check("flush_done_idu_reset", IDU_reset, 0);
    check("flush_done_fetch_ready", fetch_ready, 1);
  endtask

  task automatic do_fetch(input logic [31:0] ins, input logic [31:0] pc);
    int n = 0;
    step();
    fetch_valid = 1'b1;
    fetch_instr = ins;
    fetch_pc    = pc;
    smp();
    while (!fetch_ready && n < 20) begin
      step();
      smp();
      n++;
    end
    check("fetch_ready_wait", fetch_ready, 1);
    step();
    fetch_valid = 1'b0;
    smp();
    check("decode_start_issue", decode_start, 1);
    check("cu_ir_issue", Cu_IR, ins);
    check("fetch_ready_busy", fetch_ready, 0);
  endtask

  task automatic issue_and_capture(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] imm, input logic [31:0] inc,
                                   input logic inv, input int dly);
    do_fetch(ins, pc);
    for (int i = 1; i < dly; i++) begin
      step();
      IDU_ready = 1'b0;
      smp();
      check("decode_start_wait", decode_start, 0);
      check("ex_valid_wait", ex_valid, 0);
      check("cu_ir_wait", Cu_IR, ins);
    end
    step();
    IDU_ready  = 1'b1;
    dec_fields = mk(imm, inc, inv);
    push(inv ? K_ILL : K_EX, dec_fields, pc, inc);
    smp();
    check("cu_ir_edge", Cu_IR, ins);
  endtask

  task automatic drain(input int hold, input logic [31:0] epc, input logic [31:0] enpc);
    for (int i = 0; i <= hold; i++) begin
      step();
      ex_ready  = (i == hold);
      IDU_ready = 1'b0;
      smp();
      check("hold_ex_valid", ex_valid, 1);
      check("hold_ex_pc", ex_pc, epc);
      check("hold_ex_next_pc", ex_next_pc, enpc);
      check("hold_fetch_ready", fetch_ready, 0);
    end
    step();
    ex_ready = 1'b0;
    smp();
    check("post_hold_ex_valid", ex_valid, 0);
    check("post_hold_fetch_ready", fetch_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ID_reset    = 1'b1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    fetch_instr = '0;
    fetch_pc    = '0;
    IDU_ready   = 1'b0;
    dec_fields  = '0;
    ex_ready    = 1'b0;

    // Reset state
    step();
    step();
    smp();
    check("rst_idu_reset", IDU_reset, 1);
    check("rst_fetch_ready", fetch_ready, 0);
    check("rst_decode_start", decode_start, 0);
    check("rst_cu_ir", Cu_IR, 0);
    check("rst_ex", {ex_valid, ex_bundle, ex_pc, ex_next_pc}, 0);
    check("rst_traps", {trap_illegal, trap_timeout}, 0);
    step();
    ID_reset = 1'b0;
    smp();
    check("rst_rel_idu_reset", IDU_reset, 1);
    chk_flush();
    check("idle_ex_valid", ex_valid, 0);

    // Normal decode, ready 4 cycles after decode_start, held 3 cycles
    issue_and_capture(32'h0050_0093, 32'h0000_0100, 32'd5, 32'd4, 1'b0, 4);
    drain(3, 32'h0000_0100, 32'h0000_0104);

    // Compressed-size increment, longer decode, immediate ex_ready
    issue_and_capture(32'h00A1_0113, 32'h0000_2000, 32'd10, 32'd2, 1'b0, 5);
    drain(0, 32'h0000_2000, 32'h0000_2002);

    // PC wrap
    issue_and_capture(32'h0000_0013, 32'hFFFF_FFFC, 32'd0, 32'd4, 1'b0, 4);
    drain(1, 32'hFFFF_FFFC, 32'h0000_0000);

    // Illegal instruction
    issue_and_capture(32'hFFFF_FFFF, 32'h0000_0300, 32'd0, 32'd4, 1'b1, 4);
    step();
    IDU_ready = 1'b0;
    smp();
    check("ill_trap", trap_illegal, 1);
    check("ill_ex_valid", ex_valid, 0);
    check("ill_idu_reset", IDU_reset, 1);
    chk_flush();

    // Stale ready: high through ISSUE and never dropped
    IDU_ready  = 1'b1;
    dec_fields = mk(32'd7, 32'd4, 1'b0);
    push(K_TMO, '0, '0, '0);
    do_fetch(32'h0070_0193, 32'h0000_0400);
    for (int i = 0; i < 16; i++) begin
      step();
      smp();
      check("stale_no_trap", trap_timeout, 0);
      check("stale_ex_valid", ex_valid, 0);
      check("stale_idu_reset", IDU_reset, 0);
    end
    step();
    smp();
    check("tmo_trap", trap_timeout, 1);
    check("tmo_idu_reset", IDU_reset, 1);
    check("tmo_ex_valid", ex_valid, 0);
    IDU_ready = 1'b0;
    chk_flush();

    // Flush in WAIT, then a clean decode
    do_fetch(32'h0010_0213, 32'h0000_0500);
    step();
    smp();
    step();
    flush = 1'b1;
    smp();
    check("flush_wait_fetch_ready", fetch_ready, 0);
    step();
    flush = 1'b0;
    smp();
    check("flush_wait_idu_reset", IDU_reset, 1);
    check("flush_wait_ex_valid", ex_valid, 0);
    check("flush_wait_decode_start", decode_start, 0);
    chk_flush();
    issue_and_capture(32'h0020_0293, 32'h0000_0600, 32'd2, 32'd4, 1'b0, 4);
    drain(2, 32'h0000_0600, 32'h0000_0604);

    // Flush in HOLD drops the presented bundle
    issue_and_capture(32'h0030_0313, 32'h0000_0700, 32'd3, 32'd4, 1'b0, 3);
    step();
    IDU_ready = 1'b0;
    smp();
    check("hold_pre_flush_ex_valid", ex_valid, 1);
    step();
    flush = 1'b1;
    smp();
    step();
    flush = 1'b0;
    smp();
    check("flush_hold_ex_valid", ex_valid, 0);
    check("flush_hold_idu_reset", IDU_reset, 1);
    void'(sb.pop_back());
    chk_flush();

    // Flush together with fetch_valid in IDLE: not accepted
    step();
    flush       = 1'b1;
    fetch_valid = 1'b1;
    fetch_instr = 32'hDEAD_BEEF;
    fetch_pc    = 32'h0000_0800;
    smp();
    check("flush_fetch_ready", fetch_ready, 0);
    step();
    flush       = 1'b0;
    fetch_valid = 1'b0;
    smp();
    check("flush_fetch_decode_start", decode_start, 0);
    check("flush_fetch_idu_reset", IDU_reset, 1);
    check("flush_fetch_cu_ir", Cu_IR, 32'h0030_0313);
    chk_flush();

    // Recovery decode
    issue_and_capture(32'h0040_0393, 32'h0000_0900, 32'd4, 32'd4, 1'b0, 4);
    drain(1, 32'h0000_0900, 32'h0000_0904);

    step();
    smp();
    check("sb_leftover", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
